regfile_read_ctrl: RTL and testbench

//  Read-side control for the 32-entry register file; the counterpart of the write-enable decoder.
//  Two combinational core read ports (x0 hardwired to zero) serve the single-cycle datapath.
//  A sequential dump engine streams all 32 registers over a valid/ready interface for debug/test.

---
 rtl/regfile_read_ctrl.sv | 123 ++++++++++++
 tb/tb_regfile_read_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_ctrl.sv
// rtl/regfile_read_ctrl.sv - register file read ports and debug dump engine (optional REGREAD_FWD_EN write bypass)
module regfile_read_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]   regs_flat,
    input  logic                                    wr_en,
    input  logic [ADDR_WIDTH-1:0]                   wr_sel,
    input  logic [DATA_WIDTH-1:0]                   wr_data,
    input  logic [ADDR_WIDTH-1:0]                   rd_addr1,
    input  logic [ADDR_WIDTH-1:0]                   rd_addr2,
    output logic [DATA_WIDTH-1:0]                   rd_data1,
    output logic [DATA_WIDTH-1:0]                   rd_data2,
    input  logic                                    dump_start,
    input  logic                                    dump_ready,
    output logic                                    dump_valid,
    output logic [ADDR_WIDTH-1:0]                   dump_idx,
    output logic [DATA_WIDTH-1:0]                   dump_data,
    output logic                                    dump_busy,
    output logic                                    dump_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_WIDTH-1:0] next_idx;
    logic [DATA_WIDTH-1:0] next_data;

    // Shared read function: x0 is hardwired to zero, optional same-cycle write bypass
    function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] val;
        if (addr == '0) begin
            val = '0;
        end
`ifdef REGREAD_FWD_EN
        else if (wr_en && (wr_sel == addr)) begin
            val = wr_data;
        end
`endif
        else begin
            val = regs_flat[addr*DATA_WIDTH +: DATA_WIDTH];
        end
        return val;
    endfunction

`ifndef REGREAD_FWD_EN
    // Write-path inputs only matter when the bypass is built in
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_sel, wr_data};
`endif

    assign rd_data1  = read_reg(rd_addr1);
    assign rd_data2  = read_reg(rd_addr2);
    assign next_idx  = dump_idx + 1'b1;
    assign next_data = read_reg(next_idx);

    assign dump_valid = (state == SEND);
    assign dump_busy  = (state != IDLE);
    assign dump_done  = (state == DONE);

    // State register; reset aborts any dump in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start only sampled in IDLE, leave SEND once beat 31 is accepted
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dump_start) state_nxt = SEND;
            SEND:    if (dump_ready && (dump_idx == LAST_IDX)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Beat capture: index/data only move on accept, so a stalled beat stays a snapshot
    always_ff @(posedge clk) begin
        if (reset) begin
            dump_idx  <= '0;
            dump_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dump_start) begin
                        dump_idx  <= '0;
                        dump_data <= read_reg('0);
                    end
                end
                SEND: begin
                    if (dump_ready) begin
                        if (dump_idx != LAST_IDX) begin
                            dump_idx  <= next_idx;
                            dump_data <= next_data;
                        end else begin
                            dump_idx  <= '0;
                            dump_data <= '0;
                        end
                    end
                end
                default: begin
                    dump_idx  <= dump_idx;
                    dump_data <= dump_data;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_read_ctrl.sv
// tb/tb_regfile_read_ctrl.sv - directed-vector bench for regfile_read_ctrl
module tb_regfile_read_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic            clk;
    logic            reset;
    logic [NR*DW-1:0] regs_flat;
    logic [DW-1:0]   regs [NR];
    logic            wr_en;
    logic [AW-1:0]   wr_sel;
    logic [DW-1:0]   wr_data;
    logic [AW-1:0]   rd_addr1;
    logic [AW-1:0]   rd_addr2;
    logic [DW-1:0]   rd_data1;
    logic [DW-1:0]   rd_data2;
    logic            dump_start;
    logic            dump_ready;
    logic            dump_valid;
    logic [AW-1:0]   dump_idx;
    logic [DW-1:0]   dump_data;
    logic            dump_busy;
    logic            dump_done;

    int n_vec;
    int n_miss;

    regfile_read_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .regs_flat  (regs_flat),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) regs_flat[i*DW +: DW] = regs[i];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " valid"}, 32'(dump_valid), 32'd0);
        chk({tag, " idx"},   32'(dump_idx),   32'd0);
        chk({tag, " data"},  dump_data,       32'd0);
        chk({tag, " busy"},  32'(dump_busy),  32'd0);
        chk({tag, " done"},  32'(dump_done),  32'd0);
    endtask

    logic [31:0] fwd_exp;
    bit          seen_done;

    initial begin
        n_vec = 0;
        n_miss = 0;
        reset = 1'b1;
        wr_en = 1'b0;
        wr_sel = '0;
        wr_data = '0;
        rd_addr1 = '0;
        rd_addr2 = '0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        for (int i = 0; i < NR; i++) regs[i] = '0;

        tick();
        tick();
        reset = 1'b0;
        #1;
        chk_idle("por");

        // Plain reads, x0 forced to zero even when bank holds garbage
        regs[0] = 32'hFFFF_FFFF;
        regs[5] = 32'hDEAD_BEEF;
        rd_addr1 = 5'd5;
        rd_addr2 = 5'd0;
        #1;
        chk("rd1 reg5", rd_data1, 32'hDEAD_BEEF);
        chk("rd2 x0",   rd_data2, 32'h0);

        // Same-cycle write to the read address
        regs[7] = 32'h0;
        wr_en = 1'b1;
        wr_sel = 5'd7;
        wr_data = 32'h0000_1234;
        rd_addr1 = 5'd7;
        rd_addr2 = 5'd5;
`ifdef REGREAD_FWD_EN
        fwd_exp = 32'h0000_1234;
`else
        fwd_exp = 32'h0;
`endif
        #1;
        chk("fwd rd1 reg7", rd_data1, fwd_exp);
        chk("fwd rd2 other", rd_data2, 32'hDEAD_BEEF);
        wr_sel = 5'd0;
        rd_addr1 = 5'd0;
        #1;
        chk("fwd x0", rd_data1, 32'h0);
        wr_en = 1'b0;

        // Full dump with sink always ready
        for (int i = 1; i < NR; i++) regs[i] = i * 32'h11;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("dump valid %0d", i), 32'(dump_valid), 32'd1);
            chk($sformatf("dump idx %0d", i),   32'(dump_idx),   i);
            chk($sformatf("dump data %0d", i),  dump_data,       i * 32'h11);
            chk($sformatf("dump busy %0d", i),  32'(dump_busy),  32'd1);
            tick();
        end
        chk("done pulse", 32'(dump_done), 32'd1);
        chk("done valid", 32'(dump_valid), 32'd0);
        chk("done busy", 32'(dump_busy), 32'd1);
        tick();
        chk("after done pulse", 32'(dump_done), 32'd0);
        chk("after done busy", 32'(dump_busy), 32'd0);

        // Backpressure at idx 4 with a write to reg4 while stalled
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("bp pre idx", 32'(dump_idx), 32'd4);
        chk("bp pre data", dump_data, 32'h44);
        dump_ready = 1'b0;
        regs[4] = 32'hBAD0_BAD0;
        wr_en = 1'b1;
        wr_sel = 5'd4;
        wr_data = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp stall idx %0d", i), 32'(dump_idx), 32'd4);
            chk($sformatf("bp stall data %0d", i), dump_data, 32'h44);
            chk($sformatf("bp stall valid %0d", i), 32'(dump_valid), 32'd1);
        end
        wr_en = 1'b0;
        regs[4] = 32'h44;
        dump_ready = 1'b1;
        tick();
        chk("bp resume idx", 32'(dump_idx), 32'd5);
        chk("bp resume data", dump_data, 32'h55);
        seen_done = 1'b0;
        for (int i = 0; i < 64 && !seen_done; i++) begin
            if (dump_done) seen_done = 1'b1;
            else tick();
        end
        chk("bp drain done", 32'(seen_done), 32'd1);
        tick();

        // Start held high: no restart while busy, new dump only after IDLE
        dump_start = 1'b1;
        tick();
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("hold idx %0d", i), 32'(dump_idx), i);
            tick();
        end
        chk("hold done", 32'(dump_done), 32'd1);
        tick();
        chk("hold idle busy", 32'(dump_busy), 32'd0);
        chk("hold idle valid", 32'(dump_valid), 32'd0);
        tick();
        chk("hold restart valid", 32'(dump_valid), 32'd1);
        chk("hold restart idx", 32'(dump_idx), 32'd0);
        dump_start = 1'b0;

        // Reset in the middle of a dump
        for (int i = 0; i < 10; i++) tick();
        chk("mid idx", 32'(dump_idx), 32'd10);
        chk("mid data", dump_data, 32'hAA);
        reset = 1'b1;
        tick();
        tick();
        chk_idle("rst mid");
        reset = 1'b0;
        tick();
        chk_idle("rst after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
